sda_tx_driver: RTL and testbench
================================

Name: sda_tx_driver

Overview:
- Parametrised successor to the I2C slave SDA output select.
- Sequences the slave's SDA output on the slave's own register:
  - shifts out a DATA_W-bit transmit word;
  - inserts a programmable data hold time after each SCL falling edge;
  - samples the master's ACK/NACK while the bus is released.
- Sits between the slave controller FSM (supplies mode/data) and the SDA pad driver.

Parameters:
DATA_W, 8, transmit word width in bits (>=2)
HOLD_CYCLES, 3, clk cycles between detected SCL fall and SDA update (0..255)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
scl_in  in  1  SCL, already synchronised to clk
sda_in  in  1  SDA, already synchronised to clk
sda_mode  in  2  00 idle, 01 drive low (ack/start), 10 release, 11 transmit
tx_data  in  DATA_W  word to transmit
load  in  1  one-cycle pulse: capture tx_data, clear bit counter
sda_out  out  1  registered SDA output value (1 = released)
byte_done  out  1  one-cycle pulse after DATA_W-th SCL rise in transmit mode
ack_valid  out  1  one-cycle pulse when ACK bit sampled
rx_nack  out  1  last sampled ACK bit (1 = NACK)
busy  out  1  hold timer running

Behaviour:
- Reset (async, n_rst=0):
  - sda_out=1, byte_done=0, ack_valid=0, rx_nack=0, busy=0;
  - shift reg=0, bit_cnt=0, scl_prev=1, FSM=WAIT.
- Edge detect:
  - fall = scl_prev & ~scl_in;
  - rise = ~scl_prev & scl_in;
  - scl_prev registered every cycle.
- Hold FSM, states WAIT and HOLD:
  - WAIT: on fall, load hold counter with HOLD_CYCLES and go to HOLD. If HOLD_CYCLES=0, commit directly instead.
  - HOLD: decrement each cycle. At 0, commit and return to WAIT.
  - busy=1 in HOLD.
  - Latency: sda_out shows the new value exactly HOLD_CYCLES+1 clk edges after the cycle in which fall is detected.
- Commit target, sampled at commit time, not at fall:
  - mode 01 -> 0;
  - mode 10 -> 1;
  - mode 11 -> shift[DATA_W-1] (MSB_FIRST=1) or shift[0] (MSB_FIRST=0).
- Mode 00:
  - sda_out=1 on the next edge;
  - FSM forced to WAIT, counter cleared, bit_cnt cleared;
  - overrides any pending commit.
- Fall detected while in HOLD (SCL glitch): counter restarts from HOLD_CYCLES.
- load:
  - shift <= tx_data, bit_cnt <= 0;
  - does not itself change sda_out; the first bit appears at the next commit.
- Transmit shifting, on rise with mode 11:
  - shift moves one place toward the output end (left if MSB_FIRST, right otherwise), zero fill;
  - bit_cnt++.
  - When bit_cnt reaches DATA_W: byte_done=1 for one cycle, bit_cnt <= 0.
  - bit_cnt width = clog2(DATA_W+1).
- load and rise in the same cycle: load wins, no shift, bit_cnt=0.
- ACK sampling, on rise with mode 10:
  - rx_nack <= sda_in;
  - ack_valid=1 for one cycle.
  - rx_nack holds its value until the next sample.
- Mode change between fall and commit: the new mode's value is driven at commit.
- sda_out changes only at commit or on entry to mode 00; never while scl_in is high, except for mode 00.

Test Plan:
- Reset:
  - Stimulus: assert n_rst=0 mid-HOLD with sda_out=0.
  - Response: sda_out=1, busy=0, byte_done=0 immediately; after release, FSM is in WAIT.
- Byte transmit, DATA_W=8, HOLD_CYCLES=3, MSB_FIRST=1:
  - Stimulus: load 8'hA5, mode 11, 8 SCL pulses of 20 clk each.
  - Response: sda_out sequence 1,0,1,0,0,1,0,1, each changing 4 clk after its SCL fall; byte_done pulses once, 1 cycle after 8th rise.
- LSB-first:
  - Stimulus: MSB_FIRST=0, load 8'hA5.
  - Response: sda_out sequence 1,0,1,0,0,1,0,1 reversed per bit order, i.e. 1,0,1,0,0,1,0,1 read from bit0 = 1,0,1,0,0,1,0,1 -> verify as bits 0..7 of A5 = 1,0,1,0,0,1,0,1.
- ACK sample:
  - Stimulus: mode 10, sda_in=1 at SCL rise.
  - Response: ack_valid 1-cycle pulse, rx_nack=1. Repeat with sda_in=0 -> rx_nack=0.
- Hold/glitch:
  - Stimulus: second fall 2 clk after first (HOLD_CYCLES=3).
  - Response: commit 4 clk after the second fall, not the first; mode changed 01->10 during hold drives 1.
- Idle override:
  - Stimulus: mode 00 asserted during HOLD with pending target 0.
  - Response: sda_out=1 next edge, busy=0, no later commit.

Source files
------------

// File: rtl/sda_tx_driver_if.sv
// Bus between the slave controller (master side) and the SDA transmit driver (slave side).
// Carries mode/data requests in, and the SDA drive value plus status pulses out.
interface sda_tx_driver_if #(
  parameter int DATA_W = 8
);
  logic              scl_in;
  logic              sda_in;
  logic [1:0]        sda_mode;
  logic [DATA_W-1:0] tx_data;
  logic              load;
  logic              sda_out;
  logic              byte_done;
  logic              ack_valid;
  logic              rx_nack;
  logic              busy;

  modport master (
    output scl_in, sda_in, sda_mode, tx_data, load,
    input  sda_out, byte_done, ack_valid, rx_nack, busy
  );

  modport slave (
    input  scl_in, sda_in, sda_mode, tx_data, load,
    output sda_out, byte_done, ack_valid, rx_nack, busy
  );
endinterface

// File: rtl/sda_tx_driver.sv
// I2C slave SDA output sequencer: shifts out a transmit word, applies a data hold time
// after each SCL fall, and samples the master's ACK/NACK while the bus is released.
module sda_tx_driver #(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 3,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic            clk,
  input  logic            n_rst,
  sda_tx_driver_if.slave  bus
);

  localparam int              CNT_W     = $clog2(DATA_W + 1);
  localparam logic [7:0]      HOLD_LD   = 8'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(DATA_W - 1);

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_LOW   = 2'b01;
  localparam logic [1:0] MODE_REL   = 2'b10;
  localparam logic [1:0] MODE_TX    = 2'b11;

  typedef enum logic {ST_WAIT, ST_HOLD} state_t;

  state_t            r_state;
  logic [7:0]        r_hold_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_scl_prev;
  logic              r_sda_out;
  logic              r_byte_done;
  logic              r_ack_valid;
  logic              r_rx_nack;
  logic              r_busy;

  logic              w_fall;
  logic              w_rise;
  logic              w_head_bit;
  logic              w_target;
  logic [DATA_W-1:0] w_shift_next;

  assign w_fall       = r_scl_prev & ~bus.scl_in;
  assign w_rise       = ~r_scl_prev & bus.scl_in;
  assign w_head_bit   = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
  assign w_shift_next = MSB_FIRST ? {r_shift[DATA_W-2:0], 1'b0} : {1'b0, r_shift[DATA_W-1:1]};

  // Target is evaluated at commit time so a mode change during the hold window takes effect.
  always_comb begin
    w_target = 1'b1;
    case (bus.sda_mode)
      MODE_LOW: w_target = 1'b0;
      MODE_REL: w_target = 1'b1;
      MODE_TX:  w_target = w_head_bit;
      default:  w_target = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_WAIT;
      r_hold_cnt  <= 8'd0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_scl_prev  <= 1'b1;
      r_sda_out   <= 1'b1;
      r_byte_done <= 1'b0;
      r_ack_valid <= 1'b0;
      r_rx_nack   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_scl_prev  <= bus.scl_in;
      r_byte_done <= 1'b0;
      r_ack_valid <= 1'b0;

      // A load in the same cycle as a rise wins: the new word is not shifted.
      if (bus.load) begin
        r_shift   <= bus.tx_data;
        r_bit_cnt <= '0;
      end else if (w_rise && bus.sda_mode == MODE_TX) begin
        r_shift <= w_shift_next;
        if (r_bit_cnt == BITS_LAST) begin
          r_byte_done <= 1'b1;
          r_bit_cnt   <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end

      if (w_rise && bus.sda_mode == MODE_REL) begin
        r_rx_nack   <= bus.sda_in;
        r_ack_valid <= 1'b1;
      end

      if (bus.sda_mode == MODE_IDLE) begin
        r_state    <= ST_WAIT;
        r_hold_cnt <= 8'd0;
        r_busy     <= 1'b0;
        r_sda_out  <= 1'b1;
        r_bit_cnt  <= '0;
      end else begin
        case (r_state)
          ST_WAIT: begin
            if (w_fall) begin
              if (HOLD_CYCLES == 0) begin
                r_sda_out <= w_target;
              end else begin
                r_state    <= ST_HOLD;
                r_hold_cnt <= HOLD_LD;
                r_busy     <= 1'b1;
              end
            end
          end
          ST_HOLD: begin
            // A fresh fall during the hold window restarts the full hold time.
            if (w_fall) begin
              r_hold_cnt <= HOLD_LD;
            end else if (r_hold_cnt == 8'd1) begin
              r_sda_out  <= w_target;
              r_state    <= ST_WAIT;
              r_hold_cnt <= 8'd0;
              r_busy     <= 1'b0;
            end else begin
              r_hold_cnt <= r_hold_cnt - 8'd1;
            end
          end
          default: r_state <= ST_WAIT;
        endcase
      end
    end
  end

  assign bus.sda_out   = r_sda_out;
  assign bus.byte_done = r_byte_done;
  assign bus.ack_valid = r_ack_valid;
  assign bus.rx_nack   = r_rx_nack;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_sda_tx_driver.sv
// Bench for sda_tx_driver: an MSB-first/hold-3 instance and an LSB-first/hold-0 instance
// share one stimulus stream; expectations come from word bits and fall-to-commit latency.
module tb_sda_tx_driver;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          scl;
  logic          sda;
  logic [1:0]    mode;
  logic [DW-1:0] data;
  logic          ld;

  always #5 clk = ~clk;

  sda_tx_driver_if #(.DATA_W(DW)) if_m ();
  sda_tx_driver_if #(.DATA_W(DW)) if_l ();

  assign if_m.scl_in   = scl;
  assign if_m.sda_in   = sda;
  assign if_m.sda_mode = mode;
  assign if_m.tx_data  = data;
  assign if_m.load     = ld;
  assign if_l.scl_in   = scl;
  assign if_l.sda_in   = sda;
  assign if_l.sda_mode = mode;
  assign if_l.tx_data  = data;
  assign if_l.load     = ld;

  sda_tx_driver #(.DATA_W(DW), .HOLD_CYCLES(3), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (if_m.slave)
  );

  sda_tx_driver #(.DATA_W(DW), .HOLD_CYCLES(0), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (if_l.slave)
  );

  // Index 0 = MSB-first instance, index 1 = LSB-first instance.
  logic [1:0] o_sda, o_busy, o_done, o_ackv, o_nack;
  assign o_sda  = {if_l.sda_out,   if_m.sda_out};
  assign o_busy = {if_l.busy,      if_m.busy};
  assign o_done = {if_l.byte_done, if_m.byte_done};
  assign o_ackv = {if_l.ack_valid, if_m.ack_valid};
  assign o_nack = {if_l.rx_nack,   if_m.rx_nack};

  int         hold_t [2];
  logic [1:0] m_sda;
  int         n_chk;
  int         n_fail;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b1; scl = 1'b1; sda = 1'b1; mode = 2'b00; data = '0; ld = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    n_chk++; if (o_sda !== 2'b11)  begin n_fail++; $display("FAIL reset_sda got=%b exp=11", o_sda); end
    n_chk++; if (o_busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy got=%b exp=00", o_busy); end
    n_chk++; if (o_done !== 2'b00) begin n_fail++; $display("FAIL reset_done got=%b exp=00", o_done); end
    n_chk++; if (o_ackv !== 2'b00) begin n_fail++; $display("FAIL reset_ackv got=%b exp=00", o_ackv); end
    n_chk++; if (o_nack !== 2'b00) begin n_fail++; $display("FAIL reset_nack got=%b exp=00", o_nack); end
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (3) tick();
    n_chk++; if (o_sda !== 2'b11 || o_busy !== 2'b00) begin
      n_fail++; $display("FAIL reset_after_release sda=%b busy=%b exp sda=11 busy=00", o_sda, o_busy);
    end
    m_sda = 2'b11;
    $display("reset: power-up values checked");
  endtask

  task automatic test_transmit(input logic [DW-1:0] word, input bit load_on_rise);
    logic [1:0] exp_bit;
    logic       e_sda;
    logic       e_busy;
    logic [1:0] e_done;
    int         f0;
    f0 = n_fail;
    mode = 2'b11;
    if (load_on_rise) begin
      // Shift register is empty after the previous byte, so this commit drives 0.
      scl = 1'b0;
      repeat (10) tick();
      n_chk++; if (o_sda !== 2'b00) begin n_fail++; $display("FAIL tx_empty_commit got=%b exp=00", o_sda); end
      m_sda = 2'b00;
      data = word; ld = 1'b1; scl = 1'b1;
      tick();
      ld = 1'b0;
      n_chk++; if (o_done !== 2'b00) begin n_fail++; $display("FAIL tx_load_rise_done got=%b exp=00", o_done); end
      repeat (9) tick();
    end else begin
      data = word; ld = 1'b1;
      tick();
      ld = 1'b0;
      n_chk++; if (o_sda !== m_sda) begin n_fail++; $display("FAIL tx_load_no_drive got=%b exp=%b", o_sda, m_sda); end
    end
    for (int b = 0; b < DW; b++) begin
      exp_bit[0] = word[DW-1-b];
      exp_bit[1] = word[b];
      scl = 1'b0;
      for (int k = 1; k <= 10; k++) begin
        tick();
        for (int d = 0; d < 2; d++) begin
          e_sda  = (k > hold_t[d]) ? exp_bit[d] : m_sda[d];
          e_busy = (k <= hold_t[d]);
          n_chk++; if (o_sda[d] !== e_sda) begin
            n_fail++; $display("FAIL tx_sda dut=%0d bit=%0d k=%0d got=%b exp=%b", d, b, k, o_sda[d], e_sda);
          end
          n_chk++; if (o_busy[d] !== e_busy) begin
            n_fail++; $display("FAIL tx_busy dut=%0d bit=%0d k=%0d got=%b exp=%b", d, b, k, o_busy[d], e_busy);
          end
        end
        n_chk++; if (o_done !== 2'b00) begin n_fail++; $display("FAIL tx_done_low bit=%0d got=%b exp=00", b, o_done); end
      end
      m_sda = exp_bit;
      scl = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        tick();
        e_done = (k == 1 && b == DW - 1) ? 2'b11 : 2'b00;
        n_chk++; if (o_done !== e_done) begin
          n_fail++; $display("FAIL tx_done bit=%0d k=%0d got=%b exp=%b", b, k, o_done, e_done);
        end
        n_chk++; if (o_sda !== m_sda) begin
          n_fail++; $display("FAIL tx_sda_high bit=%0d k=%0d got=%b exp=%b", b, k, o_sda, m_sda);
        end
        n_chk++; if (o_ackv !== 2'b00) begin n_fail++; $display("FAIL tx_ackv got=%b exp=00", o_ackv); end
      end
    end
    $display("transmit word=%h load_on_rise=%0d new_failures=%0d", word, load_on_rise, n_fail - f0);
  endtask

  task automatic test_ack(input logic bitv);
    logic e_sda;
    mode = 2'b10; scl = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        e_sda = (k > hold_t[d]) ? 1'b1 : m_sda[d];
        n_chk++; if (o_sda[d] !== e_sda) begin
          n_fail++; $display("FAIL ack_release dut=%0d k=%0d got=%b exp=%b", d, k, o_sda[d], e_sda);
        end
      end
    end
    m_sda = 2'b11;
    sda = bitv; scl = 1'b1;
    tick();
    n_chk++; if (o_ackv !== 2'b11) begin n_fail++; $display("FAIL ack_valid got=%b exp=11", o_ackv); end
    n_chk++; if (o_nack !== {bitv, bitv}) begin n_fail++; $display("FAIL ack_nack got=%b exp=%b%b", o_nack, bitv, bitv); end
    sda = ~bitv;
    tick();
    n_chk++; if (o_ackv !== 2'b00) begin n_fail++; $display("FAIL ack_pulse_len got=%b exp=00", o_ackv); end
    n_chk++; if (o_nack !== {bitv, bitv}) begin n_fail++; $display("FAIL ack_hold got=%b exp=%b%b", o_nack, bitv, bitv); end
    n_chk++; if (o_sda !== 2'b11) begin n_fail++; $display("FAIL ack_sda_high got=%b exp=11", o_sda); end
    repeat (3) tick();
    $display("ack sample sda_in=%b rx_nack=%b", bitv, o_nack[0]);
  endtask

  task automatic test_glitch();
    logic e_busy;
    mode = 2'b01; scl = 1'b0;
    tick();
    n_chk++; if (o_sda[1] !== 1'b0) begin n_fail++; $display("FAIL glitch_h0_commit got=%b exp=0", o_sda[1]); end
    n_chk++; if (o_busy[0] !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_first got=%b exp=1", o_busy[0]); end
    scl = 1'b1;
    tick();
    scl = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 2) mode = 2'b10;
      e_busy = (k <= 3);
      // An unrestarted hold would commit mode 01 (drive 0) two cycles into this window.
      n_chk++; if (o_sda[0] !== 1'b1) begin n_fail++; $display("FAIL glitch_sda k=%0d got=%b exp=1", k, o_sda[0]); end
      n_chk++; if (o_busy[0] !== e_busy) begin n_fail++; $display("FAIL glitch_busy k=%0d got=%b exp=%b", k, o_busy[0], e_busy); end
      n_chk++; if (o_sda[1] !== 1'b0) begin n_fail++; $display("FAIL glitch_h0_sda k=%0d got=%b exp=0", k, o_sda[1]); end
    end
    m_sda = 2'b01;
    scl = 1'b1;
    tick();
    $display("glitch: hold restarted, late mode change driven");
  endtask

  task automatic test_idle();
    mode = 2'b01; scl = 1'b0;
    tick(); tick();
    n_chk++; if (o_busy[0] !== 1'b1 || o_sda[0] !== 1'b1) begin
      n_fail++; $display("FAIL idle_pending busy=%b sda=%b exp busy=1 sda=1", o_busy[0], o_sda[0]);
    end
    n_chk++; if (o_sda[1] !== 1'b0) begin n_fail++; $display("FAIL idle_h0_low got=%b exp=0", o_sda[1]); end
    mode = 2'b00;
    tick();
    n_chk++; if (o_sda !== 2'b11 || o_busy !== 2'b00) begin
      n_fail++; $display("FAIL idle_override sda=%b busy=%b exp sda=11 busy=00", o_sda, o_busy);
    end
    mode = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_chk++; if (o_sda !== 2'b11 || o_busy !== 2'b00) begin
        n_fail++; $display("FAIL idle_no_commit k=%0d sda=%b busy=%b exp sda=11 busy=00", k, o_sda, o_busy);
      end
    end
    m_sda = 2'b11;
    scl = 1'b1;
    tick();
    $display("idle override: pending commit cancelled");
  endtask

  task automatic test_reset_mid_hold();
    mode = 2'b01; scl = 1'b0;
    repeat (4) tick();
    n_chk++; if (o_sda !== 2'b00) begin n_fail++; $display("FAIL rst_pre_low got=%b exp=00", o_sda); end
    scl = 1'b1; tick();
    scl = 1'b0; tick();
    n_chk++; if (o_busy[0] !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got=%b exp=1", o_busy[0]); end
    #2 n_rst = 1'b0;
    #1;
    n_chk++; if (o_sda !== 2'b11)  begin n_fail++; $display("FAIL rst_mid_sda got=%b exp=11", o_sda); end
    n_chk++; if (o_busy !== 2'b00) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=00", o_busy); end
    n_chk++; if (o_done !== 2'b00 || o_ackv !== 2'b00 || o_nack !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_flags done=%b ackv=%b nack=%b exp 00", o_done, o_ackv, o_nack);
    end
    scl = 1'b1;
    tick(); tick();
    n_rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_chk++; if (o_sda !== 2'b11 || o_busy !== 2'b00) begin
        n_fail++; $display("FAIL rst_wait k=%0d sda=%b busy=%b exp sda=11 busy=00", k, o_sda, o_busy);
      end
    end
    $display("reset mid-hold: outputs released, back in wait");
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    hold_t[0] = 3; hold_t[1] = 0;
    test_reset();
    test_transmit(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) test_transmit(DW'($urandom), 1'b0);
    test_ack(1'b1);
    test_ack(1'b0);
    test_ack(1'($urandom_range(0, 1)));
    test_transmit(DW'($urandom), 1'b1);
    test_ack(1'b1);
    test_glitch();
    test_idle();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
